// File: rtl/stack_controller.sv
// Operand stack controller: top two entries in registers, deeper
// entries spill to a synchronous-read RAM with a one-cycle refill.
module stack_controller #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  din,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  top_of_stack,
  output logic [WIDTH-1:0]  second_of_stack,
  output logic [ADDR_W+1:0] depth,
  output logic              empty,
  output logic              full,
  output logic              err
);

  typedef logic [ADDR_W+1:0] dep_t;
  typedef logic [ADDR_W:0]   sp_t;

  localparam dep_t CAP   = dep_t'((1 << ADDR_W) + 2);
  localparam dep_t D_ONE = dep_t'(1);
  localparam dep_t D_TWO = dep_t'(2);
  localparam dep_t D_THR = dep_t'(3);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  dep_t             depth_q, depth_d;
  sp_t              sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en, rd_en;
  logic             legal;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] ram [2**ADDR_W];

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic is_push, is_pop, is_dup;
  logic is_swap, is_alu, is_repl;

  assign is_push = (op == 3'd1);
  assign is_pop  = (op == 3'd2);
  assign is_dup  = (op == 3'd3);
  assign is_swap = (op == 3'd4);
  assign is_alu  = (op == 3'd5);
  assign is_repl = (op == 3'd6);

  assign wr_addr = sp_q[ADDR_W-1:0];
  assign rd_addr = sp_q[ADDR_W-1:0] - 1'b1;

  always_comb begin
    legal = 1'b1;
    case (op)
      3'd1, 3'd3: legal = (depth_q < CAP);
      3'd2, 3'd6: legal = (depth_q >= D_ONE);
      3'd4, 3'd5: legal = (depth_q >= D_TWO);
      3'd7:       legal = 1'b0;
      default:    legal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    sec_d   = sec_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    if (clr_err) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            unique case (1'b1)
              is_push, is_dup: begin
                top_d   = is_push ? din : top_q;
                sec_d   = top_q;
                depth_d = depth_q + D_ONE;
                if (depth_q >= D_TWO) begin
                  wr_en = 1'b1;
                  sp_d  = sp_q + 1'b1;
                end
              end
              is_pop, is_alu: begin
                top_d   = is_pop ? sec_q : din;
                depth_d = depth_q - D_ONE;
                // second is refilled from RAM on the following edge
                if (depth_q >= D_THR) begin
                  rd_en   = 1'b1;
                  sp_d    = sp_q - 1'b1;
                  state_d = FILL;
                end else begin
                  sec_d = '0;
                end
              end
              is_swap: begin
                top_d = sec_q;
                sec_d = top_q;
              end
              is_repl: top_d = din;
              default: ;
            endcase
          end
        end
      end
      FILL: begin
        sec_d   = rd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      top_q   <= '0;
      sec_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      sec_q   <= sec_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) ram[wr_addr] <= sec_q;
    if (rd_en) rd_q <= ram[rd_addr];
  end

  assign op_ready        = (state_q == IDLE);
  assign top_of_stack    = top_q;
  assign second_of_stack = sec_q;
  assign depth           = depth_q;
  assign empty           = (depth_q == '0);
  assign full            = (depth_q == CAP);
  assign err             = err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: queue-based stack model checked every
// cycle, directed scenarios with literal expectations, then random ops.
module tb_stack_controller;

  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int CAP = 18;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  din = '0;
  logic          clr_err = 1'b0;
  logic          op_ready;
  logic [W-1:0]  top_of_stack;
  logic [W-1:0]  second_of_stack;
  logic [AW+1:0] depth;
  logic          empty;
  logic          full;
  logic          err;

  stack_controller #(.WIDTH(W), .ADDR_W(AW)) dut (
    .CLK(CLK),
    .reset(reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op(op),
    .din(din),
    .clr_err(clr_err),
    .top_of_stack(top_of_stack),
    .second_of_stack(second_of_stack),
    .depth(depth),
    .empty(empty),
    .full(full),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: q[0] is the top of stack; m_fill marks the refill cycle.
  logic [W-1:0] q[$];
  bit           m_err = 1'b0;
  bit           m_fill = 1'b0;
  bit           ill;
  int           n;
  logic [W-1:0] t;

  function automatic logic [W-1:0] ent(input int i);
    return (i < q.size()) ? q[i] : '0;
  endfunction

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      q.delete();
      m_err  = 1'b0;
      m_fill = 1'b0;
    end else if (m_fill) begin
      m_fill = 1'b0;
      if (clr_err) m_err = 1'b0;
    end else begin
      ill = 1'b0;
      n   = q.size();
      if (op_valid) begin
        case (op)
          3'd1: if (n < CAP) q.push_front(din); else ill = 1'b1;
          3'd2: if (n >= 1) begin
                  void'(q.pop_front());
                  m_fill = (n >= 3);
                end else ill = 1'b1;
          3'd3: if (n < CAP) q.push_front(ent(0)); else ill = 1'b1;
          3'd4: if (n >= 2) begin
                  t = q[0]; q[0] = q[1]; q[1] = t;
                end else ill = 1'b1;
          3'd5: if (n >= 2) begin
                  void'(q.pop_front());
                  void'(q.pop_front());
                  q.push_front(din);
                  m_fill = (n >= 3);
                end else ill = 1'b1;
          3'd6: if (n >= 1) q[0] = din; else ill = 1'b1;
          3'd7: ill = 1'b1;
          default: ;
        endcase
      end
      if (ill) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (!reset) begin
      chk("op_ready", op_ready, !m_fill);
      chk("top", top_of_stack, ent(0));
      if (!m_fill) chk("second", second_of_stack, ent(1));
      chk("depth", depth, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == CAP);
      chk("err", err, m_err);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] d);
    int k = 0;
    op_valid = 1'b1;
    op = o;
    din = d;
    while (!op_ready && k < 4) begin
      @(negedge CLK);
      k++;
    end
    if (!op_ready) chk("accept_timeout", op_ready, 1);
    @(negedge CLK);
    op_valid = 1'b0;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    @(negedge CLK);
  endtask

  // Called at a negedge; reset rises mid low phase, releases mid high phase.
  task automatic do_reset();
    #2 reset = 1'b1;
    #2;
    chk("rst_top", top_of_stack, 0);
    chk("rst_second", second_of_stack, 0);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", op_ready, 1);
    @(posedge CLK);
    #2 reset = 1'b0;
    @(negedge CLK);
  endtask

  logic [2:0] tbl [16] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2,
                           3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6,
                           3'd7, 3'd0};

  initial begin
    @(negedge CLK);
    do_reset();

    issue(3'd1, 16'd1);
    issue(3'd1, 16'd4);
    chk("s1_top", top_of_stack, 4);
    chk("s1_second", second_of_stack, 1);
    chk("s1_depth", depth, 2);
    issue(3'd5, 16'd5);
    chk("s1_alu_top", top_of_stack, 5);
    chk("s1_alu_second", second_of_stack, 0);
    chk("s1_alu_depth", depth, 1);
    chk("s1_alu_ready", op_ready, 1);

    do_reset();
    for (int i = 1; i <= 5; i++) issue(3'd1, W'(i));
    issue(3'd2, 16'd0);
    chk("s2_pop_top", top_of_stack, 4);
    chk("s2_pop_ready", op_ready, 0);
    idle();
    chk("s2_fill_second", second_of_stack, 3);
    chk("s2_fill_depth", depth, 4);
    chk("s2_fill_ready", op_ready, 1);

    do_reset();
    for (int i = 0; i < CAP; i++) issue(3'd1, W'(16'h100 + i));
    chk("s3_full", full, 1);
    issue(3'd1, 16'hdead);
    chk("s3_ovf_err", err, 1);
    chk("s3_ovf_depth", depth, CAP);
    chk("s3_ovf_top", top_of_stack, 16'h111);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("s3_clr_err", err, 0);

    do_reset();
    issue(3'd2, 16'd0);
    chk("s4_unf_err", err, 1);
    chk("s4_unf_depth", depth, 0);
    chk("s4_unf_top", top_of_stack, 0);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    issue(3'd1, 16'd7);
    issue(3'd1, 16'd8);
    issue(3'd1, 16'd9);
    issue(3'd7, 16'd0);
    chk("s4_op7_err", err, 1);
    chk("s4_op7_top", top_of_stack, 9);
    chk("s4_op7_depth", depth, 3);
    issue(3'd4, 16'd0);
    chk("s4_swap_top", top_of_stack, 8);
    chk("s4_swap_second", second_of_stack, 9);
    issue(3'd3, 16'd0);
    chk("s4_dup_top", top_of_stack, 8);
    chk("s4_dup_second", second_of_stack, 8);
    chk("s4_dup_depth", depth, 4);
    issue(3'd6, 16'habcd);
    chk("s4_repl_top", top_of_stack, 16'habcd);

    do_reset();
    for (int i = 1; i <= 4; i++) issue(3'd1, W'(i));
    issue(3'd2, 16'd0);
    chk("s5_in_fill", op_ready, 0);
    do_reset();
    issue(3'd1, 16'd2);
    chk("s5_top", top_of_stack, 2);
    chk("s5_depth", depth, 1);
    chk("s5_second", second_of_stack, 0);

    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!(op_valid && !op_ready)) begin
        op_valid = ($urandom % 4) != 0;
        op = tbl[$urandom % 16];
        din = W'($urandom);
      end
      clr_err = ($urandom % 16) == 0;
      if ($urandom % 500 == 0) do_reset();
      else @(negedge CLK);
    end
    op_valid = 1'b0;
    clr_err = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
